// File: rtl/pulse_width_meter.sv
// Measures the high time of an asynchronous pulse in clk_Pulse cycles, with glitch
// rejection and an optional timeout. Define PULSE_METER_STATS_EN to add pulse_count.
module pulse_width_meter #(
  parameter int CNT_W       = 36,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 2
) (
  input  logic             clk_Pulse,
  input  logic             rst_n,
  input  logic             PL_in,
  input  logic             arm,
  input  logic [CNT_W-1:0] max_width,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic             timeout,
  output logic             busy
`ifdef PULSE_METER_STATS_EN
  ,
  output logic [15:0]      pulse_count
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, ARMED, MEASURE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       limit_q, limit_d;
  logic [CNT_W-1:0]       width_q, width_d;
  logic                   valid_q, valid_d;
  logic                   tmo_q, tmo_d;
  logic                   s, rise;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      cnt_q   <= '0;
      limit_q <= '0;
      width_q <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], PL_in};
      s_d_q   <= s;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      width_q <= width_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    width_d = width_q;
    valid_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: if (arm) begin
        state_d = WAIT_LOW;
        limit_d = max_width;
      end
      // a pulse already high when armed must end before we look for a rise
      WAIT_LOW: if (!s) state_d = ARMED;
      ARMED: if (rise) begin
        state_d = MEASURE;
        cnt_d   = CNT_W'(1);
      end
      MEASURE: begin
        if (s) begin
          if (limit_q != '0 && cnt_q == limit_q) begin
            width_d = limit_q;
            tmo_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q >= CNT_W'(MIN_WIDTH)) begin
          width_d = cnt_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign width       = width_q;
  assign width_valid = valid_q;
  assign timeout     = tmo_q;
  assign busy        = (state_q != IDLE);

`ifdef PULSE_METER_STATS_EN
  logic [15:0] pcnt_q;

  // counts on the same edge that raises width_valid
  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n)                            pcnt_q <= '0;
    else if (valid_d && pcnt_q != 16'hFFFF) pcnt_q <= pcnt_q + 16'd1;
  end

  assign pulse_count = pcnt_q;
`endif

endmodule

// File: tb/tb_pulse_width_meter.sv
// Randomised and directed bench for pulse_width_meter; a second small-counter instance
// covers counter saturation.
module tb_pulse_width_meter;
  localparam int CNT_W = 36;
  localparam int SS    = 2;
  localparam int MINW  = 2;
  localparam int SW    = 5;

  typedef struct {
    bit              some;
    bit              tmo;
    longint unsigned w;
    int              c;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n, PL_in, arm, arm_s;
  logic [CNT_W-1:0] max_width, width;
  logic [SW-1:0]    max_width_s, width_s;
  logic             width_valid, timeout, busy;
  logic             valid_s, tmo_s, busy_s;
`ifdef PULSE_METER_STATS_EN
  logic [15:0]      pulse_count, pulse_count_s;
`endif

  int  errs = 0, checks = 0;
  int  cyc = 0, both_cnt = 0, busy_low = 0;
  ev_t evq[$], sevq[$];

  pulse_width_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SS), .MIN_WIDTH(MINW)) dut (
    .clk_Pulse(clk), .rst_n(rst_n), .PL_in(PL_in), .arm(arm), .max_width(max_width),
    .width(width), .width_valid(width_valid), .timeout(timeout), .busy(busy)
`ifdef PULSE_METER_STATS_EN
    , .pulse_count(pulse_count)
`endif
  );

  pulse_width_meter #(.CNT_W(SW), .SYNC_STAGES(SS), .MIN_WIDTH(MINW)) u_sat (
    .clk_Pulse(clk), .rst_n(rst_n), .PL_in(PL_in), .arm(arm_s), .max_width(max_width_s),
    .width(width_s), .width_valid(valid_s), .timeout(tmo_s), .busy(busy_s)
`ifdef PULSE_METER_STATS_EN
    , .pulse_count(pulse_count_s)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (width_valid || timeout)
      evq.push_back('{some: 1'b1, tmo: timeout, w: {28'b0, width}, c: cyc});
    if (width_valid && timeout) both_cnt++;
    if (valid_s || tmo_s)
      sevq.push_back('{some: 1'b1, tmo: tmo_s, w: {59'b0, width_s}, c: cyc});
    if (!busy) busy_low++;
  end

  // Expected report for one armed measurement of an n-cycle pulse: rc is the first
  // edge that samples it high, fc the first edge that samples it low.
  function automatic ev_t predict(int n, longint unsigned lim, int rc, int fc, int bits);
    ev_t e;
    longint unsigned maxv = (64'd1 << bits) - 1;
    e = '{some: 1'b0, tmo: 1'b0, w: 0, c: 0};
    if (n < MINW) return e;
    e.some = 1'b1;
    if (lim != 0 && longint'(n) > lim) begin
      e.tmo = 1'b1; e.w = lim; e.c = rc + int'(lim) + SS;
    end else begin
      e.w = (longint'(n) > maxv) ? maxv : longint'(n);
      e.c = fc + SS;
    end
    return e;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm(int lim);
    arm = 1'b1; max_width = CNT_W'(lim);
    tick(1);
    arm = 1'b0; max_width = '0;
    tick(1);
  endtask

  task automatic pulse(int n, output int rc, output int fc);
    PL_in = 1'b1; rc = cyc + 1;
    tick(n);
    PL_in = 1'b0; fc = cyc + 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; PL_in = 1'b0; arm = 1'b0; arm_s = 1'b0;
    max_width = '0; max_width_s = '0;
    tick(3);
    checks++; if (width !== '0) begin errs++; $display("FAIL reset_width: got %0d want 0", width); end
    checks++; if (width_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", width_valid); end
    checks++; if (timeout !== 1'b0) begin errs++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick(4);
    checks++; if (busy !== 1'b0 || evq.size() != 0) begin
      errs++; $display("FAIL post_reset_idle: busy=%b events=%0d want 0/0", busy, evq.size()); end
  endtask

  task automatic test_basic;
    int rc, fc; ev_t e, x;
    evq.delete();
    do_arm(0); tick(3);
    pulse(100, rc, fc); tick(10);
    x = predict(100, 0, rc, fc, CNT_W);
    checks++; if (evq.size() != 1) begin errs++; $display("FAIL basic_count: got %0d events want 1", evq.size()); end
    else begin
      e = evq.pop_front();
      checks++; if (e.tmo !== x.tmo || e.w != x.w) begin
        errs++; $display("FAIL basic_width: got tmo=%b w=%0d want tmo=%b w=%0d", e.tmo, e.w, x.tmo, x.w); end
      checks++; if (e.c != x.c) begin errs++; $display("FAIL basic_latency: got cycle %0d want %0d", e.c, x.c); end
    end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy: got %b want 0", busy); end
    tick(20);
    checks++; if (width !== CNT_W'(100)) begin errs++; $display("FAIL basic_hold: got %0d want 100", width); end
  endtask

  task automatic test_timeout;
    int rc, fc; ev_t e, x;
    evq.delete();
    do_arm(50); tick(3);
    pulse(80, rc, fc); tick(10);
    x = predict(80, 50, rc, fc, CNT_W);
    checks++; if (evq.size() != 1) begin errs++; $display("FAIL timeout_count: got %0d events want 1", evq.size()); end
    else begin
      e = evq.pop_front();
      checks++; if (e.tmo !== 1'b1 || e.w != x.w || e.c != x.c) begin
        errs++; $display("FAIL timeout_event: got tmo=%b w=%0d c=%0d want tmo=1 w=%0d c=%0d", e.tmo, e.w, e.c, x.w, x.c); end
    end
  endtask

  task automatic test_wait_low;
    int rc, fc; ev_t e, x;
    evq.delete();
    PL_in = 1'b1; tick(5);
    do_arm(0); tick(30);
    PL_in = 1'b0; tick(5);
    pulse(10, rc, fc); tick(10);
    x = predict(10, 0, rc, fc, CNT_W);
    checks++; if (evq.size() != 1) begin errs++; $display("FAIL waitlow_count: got %0d events want 1", evq.size()); end
    else begin
      e = evq.pop_front();
      checks++; if (e.tmo !== 1'b0 || e.w != x.w || e.c != x.c) begin
        errs++; $display("FAIL waitlow_event: got w=%0d c=%0d want w=%0d c=%0d", e.w, e.c, x.w, x.c); end
    end
  endtask

  task automatic test_glitch;
    int rc, fc; ev_t e, x;
    evq.delete();
    do_arm(0);
    busy_low = 0;
    tick(3);
    pulse(1, rc, fc); tick(4);
    pulse(20, rc, fc); tick(2);
    #1;
    checks++; if (busy_low != 0 || evq.size() != 0) begin
      errs++; $display("FAIL glitch_busy: idle cycles=%0d events=%0d want 0/0", busy_low, evq.size()); end
    tick(8);
    x = predict(20, 0, rc, fc, CNT_W);
    checks++; if (evq.size() != 1) begin errs++; $display("FAIL glitch_count: got %0d events want 1", evq.size()); end
    else begin
      e = evq.pop_front();
      checks++; if (e.tmo !== 1'b0 || e.w != x.w || e.c != x.c) begin
        errs++; $display("FAIL glitch_event: got w=%0d c=%0d want w=%0d c=%0d", e.w, e.c, x.w, x.c); end
    end
  endtask

  task automatic test_arm_ignored;
    int rc, fc; ev_t e, x;
    evq.delete();
    do_arm(0); tick(3);
    PL_in = 1'b1; rc = cyc + 1;
    tick(5);
    arm = 1'b1; max_width = CNT_W'(5);
    tick(1);
    arm = 1'b0; max_width = '0;
    tick(20);
    PL_in = 1'b0; fc = cyc + 1;
    tick(10);
    x = predict(26, 0, rc, fc, CNT_W);
    checks++; if (evq.size() != 1) begin errs++; $display("FAIL armbusy_count: got %0d events want 1", evq.size()); end
    else begin
      e = evq.pop_front();
      checks++; if (e.tmo !== 1'b0 || e.w != x.w || e.c != x.c) begin
        errs++; $display("FAIL armbusy_event: got tmo=%b w=%0d c=%0d want tmo=0 w=%0d c=%0d", e.tmo, e.w, e.c, x.w, x.c); end
    end
  endtask

  task automatic test_reset_mid;
    int rc, fc;
    evq.delete();
    do_arm(0); tick(3);
    PL_in = 1'b1; tick(15);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (width !== '0 || width_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL midreset_outputs: w=%0d v=%b t=%b b=%b want all 0", width, width_valid, timeout, busy); end
    @(negedge clk) rst_n = 1'b1;
    tick(25);
    PL_in = 1'b0; tick(5);
    pulse(10, rc, fc); tick(20);
    checks++; if (evq.size() != 0 || busy !== 1'b0) begin
      errs++; $display("FAIL midreset_quiet: events=%0d busy=%b want 0/0", evq.size(), busy); end
  endtask

  task automatic test_saturation;
    int rc, fc; ev_t e, x;
    sevq.delete();
    arm_s = 1'b1; max_width_s = '0;
    tick(1);
    arm_s = 1'b0;
    tick(4);
    pulse(50, rc, fc); tick(10);
    x = predict(50, 0, rc, fc, SW);
    checks++; if (sevq.size() != 1) begin errs++; $display("FAIL sat_count: got %0d events want 1", sevq.size()); end
    else begin
      e = sevq.pop_front();
      checks++; if (e.tmo !== 1'b0 || e.w != x.w || e.c != x.c) begin
        errs++; $display("FAIL sat_event: got w=%0d c=%0d want w=%0d c=%0d", e.w, e.c, x.w, x.c); end
    end
    evq.delete();
  endtask

  task automatic test_random;
    int rc, fc, lim, n, ng, d; ev_t e, x;
    for (int it = 0; it < 25; it++) begin
      evq.delete();
      lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      ng  = int'($urandom_range(0, 2));
      n   = int'($urandom_range(MINW, 60));
      do_arm(lim); tick(3);
      for (int g = 0; g < ng; g++) begin
        pulse(1, rc, fc);
        d = int'($urandom_range(2, 5));
        tick(d);
      end
      pulse(n, rc, fc); tick(8);
      x = predict(n, longint'(lim), rc, fc, CNT_W);
      checks++;
      if (evq.size() != 1) begin
        errs++; $display("FAIL rand%0d_count: got %0d events want 1 (n=%0d lim=%0d)", it, evq.size(), n, lim);
      end else begin
        e = evq.pop_front();
        checks++;
        if (e.tmo !== x.tmo || e.w != x.w || e.c != x.c || busy !== 1'b0)
          begin errs++; $display("FAIL rand%0d_event: got tmo=%b w=%0d c=%0d busy=%b want tmo=%b w=%0d c=%0d busy=0 (n=%0d lim=%0d)",
                                 it, e.tmo, e.w, e.c, busy, x.tmo, x.w, x.c, n, lim); end
      end
    end
  endtask

`ifdef PULSE_METER_STATS_EN
  task automatic test_stats;
    int rc, fc;
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    do_arm(0);  tick(3); pulse(5, rc, fc);  tick(8);
    do_arm(0);  tick(3); pulse(7, rc, fc);  tick(8);
    do_arm(10); tick(3); pulse(30, rc, fc); tick(8);
    do_arm(0);  tick(3); pulse(1, rc, fc);  tick(4); pulse(9, rc, fc); tick(8);
    checks++; if (pulse_count !== 16'd3) begin errs++; $display("FAIL stats_count: got %0d want 3", pulse_count); end
  endtask
`endif

  task automatic test_exclusive;
    checks++; if (both_cnt != 0) begin errs++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_wait_low();
    test_glitch();
    test_arm_ignored();
    test_reset_mid();
    test_saturation();
    test_random();
`ifdef PULSE_METER_STATS_EN
    test_stats();
`endif
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
